// File: rtl/rtmc_stepper.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rtmc_stepper : register-bus slave driving two 4-coil steppers    |
// | Revision 1.0                                                     |
// +------------------------------------------------------------------+
module rtmc_stepper #(
    parameter int         ADDR_W   = 4,
    parameter logic [7:0] ID_VALUE = 8'hA5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] reg_addr,
    input  logic [7:0]        reg_wdat,
    input  logic              reg_wr,
    input  logic              reg_rd,
    output logic [7:0]        reg_rdat,
    output logic              reg_ack,
    output logic [7:0]        mc,
    output logic [7:0]        mc_oe,
    output logic [1:0]        busy
);
    localparam int NCH        = 2;
    localparam int A_PRESCALE = 8;
    localparam int A_ID       = 9;

    logic [3:0]     ctrl   [NCH];
    logic [7:0]     period [NCH];
    logic [7:0]     steps  [NCH];
    logic [7:0]     pcnt   [NCH];
    logic [2:0]     idx    [NCH];
    logic [NCH-1:0] step_due;
    logic [7:0]     prescale;
    logic [7:0]     tcnt;
    logic           tick;
    logic           req;
    logic           wr_en;
    logic [7:0]     rd_val;

    function automatic logic hit(input logic [ADDR_W-1:0] a, input int n);
        return a == ADDR_W'(n);
    endfunction

    function automatic logic [3:0] coil(input logic [2:0] i);
        logic [3:0] p;
        case (i)
            3'd0:    p = 4'b0001;
            3'd1:    p = 4'b0011;
            3'd2:    p = 4'b0010;
            3'd3:    p = 4'b0110;
            3'd4:    p = 4'b0100;
            3'd5:    p = 4'b1100;
            3'd6:    p = 4'b1000;
            default: p = 4'b1001;
        endcase
        return p;
    endfunction

    // An odd index in full-step mode takes a single move to realign on an even entry.
    function automatic logic [2:0] next_idx(input logic [2:0] i, input logic dir,
                                            input logic half);
        logic [2:0] d;
        d = (half || i[0]) ? 3'd1 : 3'd2;
        return dir ? i + d : i - d;
    endfunction

    assign req   = (reg_wr | reg_rd) & ~reg_ack;
    assign wr_en = req & reg_wr;
    assign tick  = (tcnt == prescale);

    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            busy[c]     = ctrl[c][0] && (steps[c] != 8'd0);
            step_due[c] = ({1'b0, pcnt[c]} + 9'd1) >=
                          ((period[c] == 8'd0) ? 9'd1 : {1'b0, period[c]});
        end
    end

    always_comb begin
        rd_val = 8'h00;
        for (int c = 0; c < NCH; c++) begin
            if (hit(reg_addr, 4*c))     rd_val = {4'h0, ctrl[c]};
            if (hit(reg_addr, 4*c + 1)) rd_val = period[c];
            if (hit(reg_addr, 4*c + 2)) rd_val = steps[c];
            if (hit(reg_addr, 4*c + 3)) rd_val = {4'h0, idx[c], busy[c]};
        end
        if (hit(reg_addr, A_PRESCALE)) rd_val = prescale;
        if (hit(reg_addr, A_ID))       rd_val = ID_VALUE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_ack  <= 1'b0;
            reg_rdat <= 8'h00;
            mc       <= 8'h00;
            mc_oe    <= 8'h00;
            prescale <= 8'h00;
            tcnt     <= 8'h00;
            for (int c = 0; c < NCH; c++) begin
                ctrl[c]   <= 4'h0;
                period[c] <= 8'h00;
                steps[c]  <= 8'h00;
                pcnt[c]   <= 8'h00;
                idx[c]    <= 3'd0;
            end
        end else begin
            reg_ack <= req;
            if (req && !reg_wr) begin
                reg_rdat <= rd_val;
            end

            tcnt <= tick ? 8'h00 : tcnt + 8'd1;
            if (wr_en && hit(reg_addr, A_PRESCALE)) begin
                prescale <= reg_wdat;
                tcnt     <= 8'h00;
            end

            for (int c = 0; c < NCH; c++) begin
                if (busy[c] && tick) begin
                    if (step_due[c]) begin
                        pcnt[c]  <= 8'h00;
                        idx[c]   <= next_idx(idx[c], ctrl[c][1], ctrl[c][2]);
                        steps[c] <= steps[c] - 8'd1;
                    end else begin
                        pcnt[c] <= pcnt[c] + 8'd1;
                    end
                end
                // Bus writes are placed last so they override a same-cycle step.
                if (wr_en) begin
                    if (hit(reg_addr, 4*c))     ctrl[c]   <= reg_wdat[3:0];
                    if (hit(reg_addr, 4*c + 1)) period[c] <= reg_wdat;
                    if (hit(reg_addr, 4*c + 2)) begin
                        steps[c] <= reg_wdat;
                        pcnt[c]  <= 8'h00;
                    end
                end
                mc[4*c +: 4]    <= ctrl[c][0] ? coil(idx[c]) : 4'b0000;
                mc_oe[4*c +: 4] <= {4{ctrl[c][3]}};
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rtmc_stepper.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_rtmc_stepper : randomized bench with integer reference model  |
// | Revision 1.0                                                     |
// +------------------------------------------------------------------+
module tb_rtmc_stepper;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] reg_addr;
    logic [7:0] reg_wdat;
    logic       reg_wr;
    logic       reg_rd;
    logic [7:0] reg_rdat;
    logic       reg_ack;
    logic [7:0] mc;
    logic [7:0] mc_oe;
    logic [1:0] busy;

    int err_cnt = 0;
    int chk_cnt = 0;
    bit mon_en  = 1'b0;

    rtmc_stepper #(.ADDR_W(4), .ID_VALUE(8'hA5)) dut (
        .clk(clk), .rst_n(rst_n), .reg_addr(reg_addr), .reg_wdat(reg_wdat),
        .reg_wr(reg_wr), .reg_rd(reg_rd), .reg_rdat(reg_rdat), .reg_ack(reg_ack),
        .mc(mc), .mc_oe(mc_oe), .busy(busy)
    );

    always #5 clk = ~clk;

    logic [3:0] coil_tab [8] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110,
                                 4'b0100, 4'b1100, 4'b1000, 4'b1001};
    logic [3:0] exp_full [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [3:0] exp_half [3] = '{4'b1001, 4'b1000, 4'b1100};
    logic [3:0] seen [$];

    // Reference model state, plain integers.
    int m_ctrl [2], m_per [2], m_steps [2], m_pos [2], m_cnt [2];
    int m_pre, m_since, m_rdat;
    bit m_ack;
    logic [7:0] m_mc, m_oe;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_busy(input int ch);
        return ((m_ctrl[ch] & 1) != 0) && (m_steps[ch] != 0);
    endfunction

    function automatic int m_move(input int p, input bit fwd, input bit half);
        int d;
        d = (half || (p % 2 == 1)) ? 1 : 2;
        return fwd ? (p + d) % 8 : (p - d + 8) % 8;
    endfunction

    function automatic int m_read(input int a);
        int ch;
        if (a < 8) begin
            ch = a / 4;
            case (a % 4)
                0:       return m_ctrl[ch];
                1:       return m_per[ch];
                2:       return m_steps[ch];
                default: return m_pos[ch] * 2 + (m_busy(ch) ? 1 : 0);
            endcase
        end
        if (a == 8) return m_pre;
        if (a == 9) return 'hA5;
        return 0;
    endfunction

    always @(posedge clk or negedge rst_n) begin : model
        bit         req, tk;
        int         rv, a, ch;
        logic [7:0] nmc, noe;
        if (!rst_n) begin
            for (int c = 0; c < 2; c++) begin
                m_ctrl[c] = 0; m_per[c] = 0; m_steps[c] = 0; m_pos[c] = 0; m_cnt[c] = 0;
            end
            m_pre = 0; m_since = 0; m_rdat = 0; m_ack = 0; m_mc = 0; m_oe = 0;
        end else begin
            req = (reg_wr || reg_rd) && !m_ack;
            a   = int'(reg_addr);
            rv  = m_read(a);
            for (int c = 0; c < 2; c++) begin
                nmc[4*c +: 4] = ((m_ctrl[c] & 1) != 0) ? coil_tab[m_pos[c]] : 4'b0000;
                noe[4*c +: 4] = ((m_ctrl[c] & 8) != 0) ? 4'hF : 4'h0;
            end
            tk = (m_since % (m_pre + 1)) == m_pre;
            for (int c = 0; c < 2; c++) begin
                if (tk && m_busy(c)) begin
                    m_cnt[c]++;
                    if (m_cnt[c] >= ((m_per[c] == 0) ? 1 : m_per[c])) begin
                        m_cnt[c]   = 0;
                        m_pos[c]   = m_move(m_pos[c], (m_ctrl[c] & 2) != 0, (m_ctrl[c] & 4) != 0);
                        m_steps[c] = m_steps[c] - 1;
                    end
                end
            end
            m_since++;
            if (req && reg_wr) begin
                if (a < 8) begin
                    ch = a / 4;
                    case (a % 4)
                        0: m_ctrl[ch] = int'(reg_wdat) & 15;
                        1: m_per[ch]  = int'(reg_wdat);
                        2: begin m_steps[ch] = int'(reg_wdat); m_cnt[ch] = 0; end
                        default: ;
                    endcase
                end else if (a == 8) begin
                    m_pre   = int'(reg_wdat);
                    m_since = 0;
                end
            end else if (req) begin
                m_rdat = rv;
            end
            m_ack = req;
            m_mc  = nmc;
            m_oe  = noe;
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            check_eq("mc", mc, m_mc);
            check_eq("mc_oe", mc_oe, m_oe);
            check_eq("busy", busy, {m_busy(1), m_busy(0)});
            check_eq("ack", reg_ack, m_ack);
            check_eq("rdat", reg_rdat, m_rdat);
        end
    end

    // Returns in the ack cycle, request already dropped.
    task automatic bus_op(input bit wr, input bit rd, input logic [3:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        reg_addr = a; reg_wdat = d; reg_wr = wr; reg_rd = rd;
        @(posedge clk); #1;
        reg_wr = 1'b0; reg_rd = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [3:0] a, input logic [7:0] exp);
        bus_op(1'b0, 1'b1, a, 8'h00);
        check_eq(tag, reg_rdat, exp);
    endtask

    task automatic watch_nib(input bit hi, input int cycles);
        logic [3:0] prev, cur;
        seen.delete();
        prev = hi ? mc[7:4] : mc[3:0];
        repeat (cycles) begin
            @(negedge clk);
            cur = hi ? mc[7:4] : mc[3:0];
            if (cur != prev) seen.push_back(cur);
            prev = cur;
        end
    endtask

    initial begin
        int i;
        rst_n = 1'b0; reg_addr = '0; reg_wdat = '0; reg_wr = 1'b0; reg_rd = 1'b0;
        repeat (3) @(posedge clk);
        mon_en = 1'b1;
        @(negedge clk); rst_n = 1'b1;

        // Full-step forward on ch0, tick every 4 clocks, 2 ticks per step.
        bus_op(1, 0, 4'd8, 8'd3);
        bus_op(1, 0, 4'd1, 8'd2);
        bus_op(1, 0, 4'd0, 8'h0B);
        bus_op(1, 0, 4'd2, 8'd4);
        watch_nib(1'b0, 44);
        check_eq("full_seq_len", seen.size(), 4);
        for (int k = 0; k < 4; k++)
            if (k < seen.size()) check_eq("full_seq", seen[k], exp_full[k]);
        check_eq("full_oe", mc_oe[3:0], 4'hF);
        rd_chk("full_status", 4'd3, 8'h00);

        // Half-step reverse on ch1, tick every clock.
        bus_op(1, 0, 4'd8, 8'd0);
        bus_op(1, 0, 4'd5, 8'd1);
        bus_op(1, 0, 4'd4, 8'h0D);
        bus_op(1, 0, 4'd6, 8'd3);
        watch_nib(1'b1, 10);
        check_eq("half_seq_len", seen.size(), 3);
        for (int k = 0; k < 3; k++)
            if (k < seen.size()) check_eq("half_seq", seen[k], exp_half[k]);
        rd_chk("half_status", 4'd7, 8'h0A);

        // Pause and resume ch0.
        bus_op(1, 0, 4'd1, 8'd20);
        bus_op(1, 0, 4'd2, 8'd5);
        i = 0;
        while (i < 300 && m_steps[0] != 2) begin
            @(negedge clk);
            i++;
        end
        check_eq("wait_steps2", m_steps[0], 2);
        bus_op(1, 0, 4'd0, 8'h0A);
        @(posedge clk); #1;
        check_eq("pause_mc", mc[3:0], 4'h0);
        rd_chk("pause_steps", 4'd2, 8'd2);
        repeat (50) @(posedge clk);
        rd_chk("pause_hold", 4'd2, 8'd2);
        bus_op(1, 0, 4'd0, 8'h0B);
        repeat (60) @(posedge clk);
        rd_chk("resume_steps", 4'd2, 8'd0);
        check_eq("resume_busy", busy[0], 1'b0);

        // Bus corner cases.
        rd_chk("unmapped", 4'd12, 8'h00);
        @(posedge clk); #1;
        check_eq("ack_pulse", reg_ack, 1'b0);
        bus_op(1, 0, 4'd3, 8'hFF);
        rd_chk("status_ro", 4'd3, 8'h04);
        rd_chk("id", 4'd9, 8'hA5);
        bus_op(1, 1, 4'd5, 8'h33);
        check_eq("wrrd_rdat", reg_rdat, 8'hA5);
        rd_chk("wrrd_write", 4'd5, 8'h33);

        // STEPS rewrite landing on a step edge.
        bus_op(1, 0, 4'd1, 8'd4);
        bus_op(1, 0, 4'd2, 8'd10);
        repeat (6) @(posedge clk);
        bus_op(1, 0, 4'd2, 8'd7);
        rd_chk("steps_rewrite", 4'd2, 8'd7);
        repeat (40) @(posedge clk);
        rd_chk("rewrite_done", 4'd2, 8'd0);

        // Randomized traffic against the model.
        for (int n = 0; n < 300; n++) begin
            logic [3:0] a;
            logic [7:0] d;
            int kind;
            a = 4'($urandom_range(0, 15));
            d = 8'($urandom);
            if (a == 4'd2 || a == 4'd6) d = 8'($urandom_range(0, 12));
            if (a == 4'd1 || a == 4'd5) d = 8'($urandom_range(0, 4));
            if (a == 4'd8)              d = 8'($urandom_range(0, 2));
            kind = $urandom_range(0, 3);
            bus_op(kind <= 1 || kind == 3, kind >= 2, a, d);
            repeat ($urandom_range(0, 4)) @(posedge clk);
        end

        // Asynchronous reset while ch0 is moving.
        bus_op(1, 0, 4'd0, 8'h0B);
        bus_op(1, 0, 4'd1, 8'd3);
        bus_op(1, 0, 4'd2, 8'd5);
        repeat (4) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check_eq("rst_mc", mc, 8'h00);
        check_eq("rst_oe", mc_oe, 8'h00);
        check_eq("rst_busy", busy, 2'b00);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int a = 0; a < 16; a++)
            rd_chk("rst_reg", 4'(a), (a == 9) ? 8'hA5 : 8'h00);

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
`default_nettype wire
